datapath_param: RTL and testbench
=================================

Name: datapath_param

Overview:
- Parametrised next-generation datapath for the multi-cycle RISC core.
- Contains:
  - a 2**REG_AW x WIDTH register file
  - A, B and C pipeline registers
  - a B-side shifter and a 4-op ALU
  - a 3-flag status register {N,V,Z}, replacing the single status bit
- Driven cycle-by-cycle by the control FSM.
- Adds synchronous reset, a 4-way writeback mux (adds PC), and signed-overflow/negative flags.

Parameters:
- WIDTH, 16, data word width in bits (>=4)
- REG_AW, 3, register index width; register count NREGS = 2**REG_AW

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- readnum  in  REG_AW  register-file read index (combinational read)
- writenum  in  REG_AW  register-file write index
- write  in  1  register-file write enable
- vsel  in  2  writeback select: 00 C, 01 pc, 10 sximm8, 11 mdata
- loada  in  1  load A from register-file read data
- loadb  in  1  load B from register-file read data
- asel  in  1  1: ALU A operand forced to 0; 0: A
- bsel  in  1  1: ALU B operand = sximm5; 0: shifter output
- shift  in  2  00 none, 01 shift left 1 (zero fill), 10 logical right 1, 11 arithmetic right 1
- ALUop  in  2  00 A+B, 01 A-B, 10 A&B, 11 ~B
- loadc  in  1  load C from ALU result
- loads  in  1  load status from ALU flags
- mdata  in  WIDTH  memory read data
- pc  in  WIDTH  program counter value for link writes
- sximm5  in  WIDTH  sign-extended 5-bit immediate
- sximm8  in  WIDTH  sign-extended 8-bit immediate
- status  out  3  {N,V,Z}, registered
- datapath_out  out  WIDTH  contents of C

Behaviour:
- Reset (sync, active-high):
  - clears all NREGS registers, A, B, C and status to 0
  - overrides write/loada/loadb/loadc/loads in the same edge
  - datapath_out=0, status=3'b000 from the first edge with reset high
- Register file:
  - read data = R[readnum], combinational
  - on the edge with write=1, R[writenum] <= wb_data (per vsel)
  - same-cycle write/read of the same index returns the old value, unless bypassed (see Optional Feature)
- A/B capture the read data on loada/loadb; the two enables are independent, and both may load in the same cycle.
- Shifter operates on B only:
  - arithmetic right replicates B[WIDTH-1]
  - left/logical-right shifts fill with 0
- ALU:
  - Ain = asel ? 0 : A
  - Bin = bsel ? sximm5 : shifted B
  - result is WIDTH bits, modular (carry-out discarded)
- Flags (computed combinationally from the current result, captured only on loads; independent of loadc):
  - Z = (result == 0)
  - N = result[WIDTH-1]
  - V (add) = Ain and Bin signs equal, and result sign differs from them
  - V (sub) = Ain and Bin signs differ, and result sign differs from Ain
  - V (AND/NOT) = 0
- C updates only on loadc; datapath_out always reflects C.
- Latency: register-to-register op takes at least 3 edges:
  - edge 1: loada/loadb
  - edge 2: loadc (+ loads)
  - edge 3: write with vsel=00
- Simultaneous loadc and write with vsel=00: the register file gets the OLD C, and C gets the new result.
- Held enables re-evaluate every edge; there is no internal state machine.
- Reset asserted mid-sequence discards all partial results.
- Unused index bits do not exist: every index value addresses a real register.

Optional Feature:
- Macro: DATAPATH_RF_BYPASS_EN
- Defined: when write=1 and writenum==readnum, the read data equals wb_data in the same cycle, so loada/loadb capture the value being written.
- Undefined: read data is always the pre-edge register contents.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: preload R0..R7 non-zero, assert reset 1 cycle → every register reads 0; status=000; datapath_out=0.
- Immediate write then ADD:
  - write R1=sximm8 0x0007 and R2=0x0005 (vsel=10)
  - load A=R1, B=R2, ALUop=00, loadc+loads, write R3 via vsel=00
  - → R3=0x000C, status=000
- SUB overflow: A=0x8000, B=0x0001, ALUop=01, loads → C=0x7FFF, status {N,V,Z}=010. Then A=B=0x1234 SUB → C=0, status=001.
- Shift and immediate:
  - B=0x8004, shift=11, ALUop=11 → C=~0xC002=0x3FFD
  - B=0x8004, shift=01, asel=1, ALUop=00 → C=0x0008
  - bsel=1, sximm5=0xFFF0, asel=1, ADD → C=0xFFF0, N=1
- Same-cycle write/read: R4=0x1111, then write R4=0x2222 with readnum=4 and loada in the same cycle → A=0x1111 without the macro, A=0x2222 with DATAPATH_RF_BYPASS_EN.
- Writeback mux and reset priority:
  - vsel=01 with pc=0x0042 → R5=0x0042
  - vsel=11 with mdata=0xBEEF → R6=0xBEEF
  - write+reset in the same cycle → R6=0
  - WIDTH=32, REG_AW=4 build: R15 writable, 0x7FFFFFFF+1 → V=1, N=1

Source files
------------

// File: rtl/datapath_param.sv
// datapath_param: parametrised RISC datapath with register file, A/B/C pipeline registers, B-side shifter, 4-op ALU and {N,V,Z} status
// Ports: clk/reset (sync, active-high); readnum/writenum/write drive the register file; vsel selects writeback (C, pc, sximm8, mdata);
// loada/loadb/loadc/loads enable the A, B, C and status registers; asel/bsel/shift/ALUop steer the ALU; status={N,V,Z}; datapath_out=C.
// Optional macro DATAPATH_RF_BYPASS_EN forwards same-cycle write data to the register-file read port.
module datapath_param #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] readnum,
  input  logic [REG_AW-1:0] writenum,
  input  logic              write,
  input  logic [1:0]        vsel,
  input  logic              loada,
  input  logic              loadb,
  input  logic              asel,
  input  logic              bsel,
  input  logic [1:0]        shift,
  input  logic [1:0]        ALUop,
  input  logic              loadc,
  input  logic              loads,
  input  logic [WIDTH-1:0]  mdata,
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  sximm5,
  input  logic [WIDTH-1:0]  sximm8,
  output logic [2:0]        status,
  output logic [WIDTH-1:0]  datapath_out
);
  localparam int NREGS = 2**REG_AW;
  localparam int MSB = WIDTH-1;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]       status_q, status_d;
  logic [WIDTH-1:0] wb_data, rd_data, b_sh, ain, bin, res;
  logic             ovf;
  always_comb begin
    wb_data = vsel == 2'b00 ? c_q : vsel == 2'b01 ? pc : vsel == 2'b10 ? sximm8 : mdata;
`ifdef DATAPATH_RF_BYPASS_EN
    rd_data = (write && writenum == readnum) ? wb_data : rf_q[readnum];
`else
    rd_data = rf_q[readnum];
`endif
    b_sh = shift == 2'b00 ? b_q :
           shift == 2'b01 ? {b_q[MSB-1:0], 1'b0} :
           shift == 2'b10 ? {1'b0, b_q[MSB:1]} : {b_q[MSB], b_q[MSB:1]};
    ain = asel ? '0 : a_q;
    bin = bsel ? sximm5 : b_sh;
    res = ALUop == 2'b00 ? ain + bin : ALUop == 2'b01 ? ain - bin : ALUop == 2'b10 ? ain & bin : ~bin;
    ovf = ALUop == 2'b00 ? (ain[MSB] == bin[MSB]) && (res[MSB] != ain[MSB]) :
          ALUop == 2'b01 ? (ain[MSB] != bin[MSB]) && (res[MSB] != ain[MSB]) : 1'b0;
    rf_d = rf_q;
    if (write) rf_d[writenum] = wb_data;
    a_d = loada ? rd_data : a_q;
    b_d = loadb ? rd_data : b_q;
    c_d = loadc ? res : c_q;
    status_d = loads ? {res[MSB], ovf, res == '0} : status_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q <= '{default: '0};
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      status_q <= '0;
    end else begin
      rf_q <= rf_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      status_q <= status_d;
    end
  end
  assign status = status_q;
  assign datapath_out = c_q;
endmodule

// File: tb/tb_datapath_param.sv
// tb_datapath_param: randomized and directed self-checking bench for datapath_param against an arithmetic reference model
module tb_datapath_param;
  localparam int W = 16;
  localparam int AW = 3;
  localparam int NR = 2**AW;
  localparam longint MAXS = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W-1));
  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] readnum, writenum;
  logic write, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0] vsel, shift, ALUop;
  logic [W-1:0] mdata, pc, sximm5, sximm8;
  logic [2:0] status;
  logic [W-1:0] datapath_out;
  logic [W-1:0] m_r [NR];
  logic [W-1:0] m_a, m_b, m_c;
  logic [2:0] m_s;
  int checks = 0;
  int failures = 0;
  datapath_param #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .loadc(loadc), .loads(loads), .mdata(mdata), .pc(pc), .sximm5(sximm5), .sximm8(sximm8),
    .status(status), .datapath_out(datapath_out)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic longint sx(logic [W-1:0] x);
    return longint'($signed(x));
  endfunction
  task automatic idle();
    reset = 0; write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0;
    asel = 0; bsel = 0; vsel = 0; shift = 0; ALUop = 0; readnum = 0; writenum = 0;
  endtask
  task automatic cyc();
    logic [W-1:0] rd, wb, bs, ain, bin, res;
    longint sa, sb, sr;
    logic v;
    case (vsel)
      2'd0: wb = m_c;
      2'd1: wb = pc;
      2'd2: wb = sximm8;
      default: wb = mdata;
    endcase
    rd = m_r[readnum];
`ifdef DATAPATH_RF_BYPASS_EN
    if (write && writenum == readnum) rd = wb;
`endif
    sb = sx(m_b);
    case (shift)
      2'd0: bs = m_b;
      2'd1: bs = W'(m_b * 2);
      2'd2: bs = m_b / 2;
      default: bs = W'(sb < 0 ? (sb - 1) / 2 : sb / 2);
    endcase
    ain = asel ? '0 : m_a;
    bin = bsel ? sximm5 : bs;
    sa = sx(ain);
    sb = sx(bin);
    case (ALUop)
      2'd0: sr = sa + sb;
      2'd1: sr = sa - sb;
      2'd2: sr = sx(ain & bin);
      default: sr = sx(~bin);
    endcase
    res = W'(sr);
    v = sr > MAXS || sr < MINS;
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < NR; i++) m_r[i] = '0;
      m_a = '0; m_b = '0; m_c = '0; m_s = '0;
    end else begin
      if (write) m_r[writenum] = wb;
      if (loada) m_a = rd;
      if (loadb) m_b = rd;
      if (loadc) m_c = res;
      if (loads) m_s = {res[W-1], v, res == '0};
    end
    chk("dout", datapath_out, m_c);
    chk("status", status, m_s);
  endtask
  task automatic wr_reg(int idx, logic [W-1:0] val);
    idle(); writenum = AW'(idx); write = 1; vsel = 2'd2; sximm8 = val; cyc();
  endtask
  task automatic ld_a(int idx);
    idle(); readnum = AW'(idx); loada = 1; cyc();
  endtask
  task automatic ld_b(int idx);
    idle(); readnum = AW'(idx); loadb = 1; cyc();
  endtask
  task automatic rd_reg(int idx, logic [W-1:0] exp);
    ld_b(idx);
    idle(); asel = 1; loadc = 1; cyc();
    chk($sformatf("R%0d", idx), datapath_out, exp);
  endtask
  initial begin
    mdata = '0; pc = '0; sximm5 = '0; sximm8 = '0;
    idle(); reset = 1; cyc();
    for (int i = 0; i < NR; i++) wr_reg(i, W'(16'h1000 + i + 1));
    idle(); reset = 1; cyc();
    chk("reset_dout", datapath_out, 0);
    chk("reset_status", status, 0);
    for (int i = 0; i < NR; i++) rd_reg(i, '0);
    wr_reg(1, 16'h0007); wr_reg(2, 16'h0005); ld_a(1); ld_b(2);
    idle(); ALUop = 2'd0; loadc = 1; loads = 1; cyc();
    chk("add_status", status, 3'b000);
    idle(); write = 1; writenum = 3; vsel = 2'd0; cyc();
    rd_reg(3, 16'h000C);
    wr_reg(1, 16'h8000); wr_reg(2, 16'h0001); ld_a(1); ld_b(2);
    idle(); ALUop = 2'd1; loadc = 1; loads = 1; cyc();
    chk("sub_ovf_c", datapath_out, 16'h7FFF);
    chk("sub_ovf_s", status, 3'b010);
    wr_reg(1, 16'h1234); ld_a(1); ld_b(1);
    idle(); ALUop = 2'd1; loadc = 1; loads = 1; cyc();
    chk("sub_zero_c", datapath_out, 16'h0000);
    chk("sub_zero_s", status, 3'b001);
    wr_reg(2, 16'h8004); ld_b(2);
    idle(); shift = 2'd3; ALUop = 2'd3; loadc = 1; cyc();
    chk("asr_not", datapath_out, 16'h3FFD);
    idle(); shift = 2'd1; asel = 1; loadc = 1; cyc();
    chk("shl_add", datapath_out, 16'h0008);
    idle(); bsel = 1; sximm5 = 16'hFFF0; asel = 1; loadc = 1; loads = 1; cyc();
    chk("imm_c", datapath_out, 16'hFFF0);
    chk("imm_s", status, 3'b100);
    idle(); asel = 1; bsel = 1; sximm5 = 16'h0005; loadc = 1; write = 1; writenum = 7; vsel = 2'd0; cyc();
    chk("wb_new_c", datapath_out, 16'h0005);
    rd_reg(7, 16'hFFF0);
    wr_reg(4, 16'h1111);
    idle(); write = 1; writenum = 4; vsel = 2'd2; sximm8 = 16'h2222; readnum = 4; loada = 1; cyc();
    idle(); bsel = 1; sximm5 = '0; loadc = 1; cyc();
`ifdef DATAPATH_RF_BYPASS_EN
    chk("same_cycle_rd", datapath_out, 16'h2222);
`else
    chk("same_cycle_rd", datapath_out, 16'h1111);
`endif
    rd_reg(4, 16'h2222);
    idle(); write = 1; writenum = 5; vsel = 2'd1; pc = 16'h0042; cyc();
    rd_reg(5, 16'h0042);
    idle(); write = 1; writenum = 6; vsel = 2'd3; mdata = 16'hBEEF; cyc();
    rd_reg(6, 16'hBEEF);
    idle(); reset = 1; write = 1; writenum = 6; vsel = 2'd3; mdata = 16'h1234; cyc();
    rd_reg(6, '0);
    for (int n = 0; n < 800; n++) begin
      reset = $urandom_range(0, 63) == 0;
      readnum = AW'($urandom); writenum = AW'($urandom);
      write = 1'($urandom); loada = 1'($urandom); loadb = 1'($urandom);
      loadc = 1'($urandom); loads = 1'($urandom);
      asel = $urandom_range(0, 3) == 0; bsel = $urandom_range(0, 3) == 0;
      vsel = 2'($urandom); shift = 2'($urandom); ALUop = 2'($urandom);
      mdata = W'($urandom); pc = W'($urandom); sximm5 = W'($urandom); sximm8 = W'($urandom);
      cyc();
    end
    for (int i = 0; i < NR; i++) rd_reg(i, m_r[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
